// File: rtl/bsg_global_buffer_pkg.sv
// Shared types for the global buffer read-only ring streamer.
package bsg_global_buffer_pkg;

   // Field widths of a burst command in the default ring configuration
   // (4 tiles, 1024-word banks, 16-bit length).
   localparam int ro_cmd_x_width_lp    = 2;
   localparam int ro_cmd_addr_width_lp = 10;
   localparam int ro_cmd_len_width_lp  = 16;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      DRAIN = 2'd2
   } ro_streamer_state_e;

   typedef struct packed {
      logic [ro_cmd_x_width_lp-1:0]    x;
      logic [ro_cmd_addr_width_lp-1:0] addr;
      logic [ro_cmd_len_width_lp-1:0]  len;
   } ro_cmd_s;

   // Index width that stays at least one bit for single-entry ranges.
   function automatic int safe_clog2(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/bsg_global_buffer_ro_resp_fifo.sv
// Response FIFO for the RO streamer: one write port from the ring, one
// valid/yumi read port, occupancy exposed for credit accounting.
module bsg_global_buffer_ro_resp_fifo
   import bsg_global_buffer_pkg::*;
#(
   parameter  int width_p      = 32,
   parameter  int els_p        = 8,
   localparam int ptr_width_lp = safe_clog2(els_p),
   localparam int cnt_width_lp = $clog2(els_p + 1)
) (
   input  logic                    clk_i,
   input  logic                    reset_n_i,
   input  logic                    v_i,
   input  logic [width_p-1:0]      data_i,
   output logic                    full_o,
   output logic [width_p-1:0]      data_o,
   output logic                    v_o,
   input  logic                    yumi_i,
   output logic [cnt_width_lp-1:0] count_o
);

   localparam logic [ptr_width_lp-1:0] ptr_last_lp = ptr_width_lp'(els_p - 1);
   localparam logic [cnt_width_lp-1:0] cnt_full_lp = cnt_width_lp'(els_p);

   logic [width_p-1:0]      mem_q [els_p];
   logic [ptr_width_lp-1:0] rd_ptr_q, rd_ptr_d;
   logic [ptr_width_lp-1:0] wr_ptr_q, wr_ptr_d;
   logic [cnt_width_lp-1:0] count_q, count_d;
   logic                    enq, deq;

   assign v_o     = (count_q != '0);
   assign full_o  = (count_q == cnt_full_lp);
   assign count_o = count_q;
   assign data_o  = mem_q[rd_ptr_q];

   // A write into a full FIFO is only taken when a read frees a slot this cycle.
   assign deq = yumi_i & v_o;
   assign enq = v_i & (~full_o | deq);

   always_comb begin
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      if (deq) rd_ptr_d = (rd_ptr_q == ptr_last_lp) ? '0 : rd_ptr_q + ptr_width_lp'(1);
      if (enq) wr_ptr_d = (wr_ptr_q == ptr_last_lp) ? '0 : wr_ptr_q + ptr_width_lp'(1);
      if (enq && !deq)      count_d = count_q + cnt_width_lp'(1);
      else if (deq && !enq) count_d = count_q - cnt_width_lp'(1);
   end

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (enq) mem_q[wr_ptr_q] <= data_i;
   end

endmodule

// File: rtl/bsg_global_buffer_ro_streamer.sv
// Burst requester for the read-only ring: issues one credit-gated request per
// cycle and collects the in-order responses into a local FIFO.
//
// state | meaning
// IDLE  | waiting for a burst command; accept cycle also issues the first word
// ISSUE | issuing one request per cycle while credits remain
// DRAIN | all requests issued; waiting for responses to return and be consumed
module bsg_global_buffer_ro_streamer
   import bsg_global_buffer_pkg::*;
#(
   parameter  int data_width_p  = 32,
   parameter  int bank_els_p    = 1024,
   parameter  int num_tiles_x_p = 4,
   parameter  int fifo_els_p    = 8,
   parameter  int len_width_p   = 16,
   localparam int x_width_lp    = safe_clog2(num_tiles_x_p),
   localparam int addr_width_lp = safe_clog2(bank_els_p),
   localparam int cnt_width_lp  = $clog2(fifo_els_p + 1)
) (
   input  logic                     clk_i,
   input  logic                     reset_n_i,
   input  logic                     cmd_v_i,
   output logic                     cmd_ready_o,
   input  logic [x_width_lp-1:0]    cmd_x_i,
   input  logic [addr_width_lp-1:0] cmd_addr_i,
   input  logic [len_width_p-1:0]   cmd_len_i,
   output logic [addr_width_lp-1:0] ro_addr_o,
   output logic [x_width_lp-1:0]    ro_dest_x_o,
   output logic                     ro_addr_v_o,
   input  logic [data_width_p-1:0]  ro_data_i,
   input  logic                     ro_data_v_i,
   output logic [data_width_p-1:0]  data_o,
   output logic                     v_o,
   input  logic                     yumi_i,
   output logic                     busy_o,
   output logic                     overflow_o
);

   localparam logic [cnt_width_lp-1:0] credits_max_lp = cnt_width_lp'(fifo_els_p);
   localparam logic [x_width_lp-1:0]   x_last_lp      = x_width_lp'(num_tiles_x_p - 1);

   ro_streamer_state_e       state_q, state_d;
   logic [x_width_lp-1:0]    cur_x_q, cur_x_d, ro_x_q, ro_x_d;
   logic [addr_width_lp-1:0] cur_addr_q, cur_addr_d, ro_addr_q, ro_addr_d;
   logic [len_width_p-1:0]   remaining_q, remaining_d;
   logic [cnt_width_lp-1:0]  credits_q, credits_d;
   logic [cnt_width_lp-1:0]  outstanding_q, outstanding_d;
   logic                     ro_v_q, ro_v_d;
   logic                     overflow_q, overflow_d;
   logic                     init_q;

   logic [x_width_lp-1:0]    base_x, next_x;
   logic [addr_width_lp-1:0] base_addr, next_addr;
   logic [len_width_p-1:0]   base_len;
   logic                     accept, issue, deq, resp_ok;
   logic                     fifo_v, fifo_full;
   logic [cnt_width_lp-1:0]  fifo_count;

   // init_q keeps cmd_ready_o low until the first clock after reset release.
   assign cmd_ready_o = init_q & (state_q == IDLE);
   assign accept      = cmd_v_i & cmd_ready_o;
   assign deq         = yumi_i & fifo_v;
   assign resp_ok     = ro_data_v_i & (outstanding_q != '0);

   always_comb begin
      state_d     = state_q;
      cur_x_d     = cur_x_q;
      cur_addr_d  = cur_addr_q;
      remaining_d = remaining_q;
      ro_v_d      = 1'b0;
      ro_x_d      = ro_x_q;
      ro_addr_d   = ro_addr_q;
      issue       = 1'b0;

      base_x    = cur_x_q;
      base_addr = cur_addr_q;
      base_len  = remaining_q;
      if (state_q == IDLE) begin
         base_x    = cmd_x_i;
         base_addr = cmd_addr_i;
         base_len  = cmd_len_i;
      end

      if (base_x == x_last_lp) begin
         next_x    = '0;
         next_addr = base_addr + addr_width_lp'(1);
      end else begin
         next_x    = base_x + x_width_lp'(1);
         next_addr = base_addr;
      end

      case (state_q)
         IDLE: begin
            if (accept) begin
               state_d     = ISSUE;
               cur_x_d     = base_x;
               cur_addr_d  = base_addr;
               remaining_d = base_len;
               issue       = (credits_q != '0);
            end
         end
         ISSUE: issue = (credits_q != '0);
         DRAIN: begin
            if ((outstanding_q == '0) && !ro_data_v_i &&
                ((fifo_count == '0) || ((fifo_count == cnt_width_lp'(1)) && deq)))
               state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      if (issue) begin
         ro_v_d      = 1'b1;
         ro_x_d      = base_x;
         ro_addr_d   = base_addr;
         cur_x_d     = next_x;
         cur_addr_d  = next_addr;
         remaining_d = base_len - len_width_p'(1);
         state_d     = (base_len == '0) ? DRAIN : ISSUE;
      end
   end

   // Credits saturate at the FIFO depth so a stray word drained in IDLE
   // cannot mint an extra credit.
   always_comb begin
      credits_d     = credits_q;
      outstanding_d = outstanding_q;
      if (issue && !deq)
         credits_d = credits_q - cnt_width_lp'(1);
      else if (deq && !issue && (credits_q != credits_max_lp))
         credits_d = credits_q + cnt_width_lp'(1);
      if (issue && !resp_ok)
         outstanding_d = outstanding_q + cnt_width_lp'(1);
      else if (resp_ok && !issue)
         outstanding_d = outstanding_q - cnt_width_lp'(1);
      overflow_d = overflow_q |
                   (ro_data_v_i & ((outstanding_q == '0) | (fifo_full & ~deq)));
   end

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state_q       <= IDLE;
         cur_x_q       <= '0;
         cur_addr_q    <= '0;
         remaining_q   <= '0;
         ro_v_q        <= 1'b0;
         ro_x_q        <= '0;
         ro_addr_q     <= '0;
         credits_q     <= credits_max_lp;
         outstanding_q <= '0;
         overflow_q    <= 1'b0;
         init_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         cur_x_q       <= cur_x_d;
         cur_addr_q    <= cur_addr_d;
         remaining_q   <= remaining_d;
         ro_v_q        <= ro_v_d;
         ro_x_q        <= ro_x_d;
         ro_addr_q     <= ro_addr_d;
         credits_q     <= credits_d;
         outstanding_q <= outstanding_d;
         overflow_q    <= overflow_d;
         init_q        <= 1'b1;
      end
   end

   bsg_global_buffer_ro_resp_fifo #(
      .width_p (data_width_p),
      .els_p   (fifo_els_p)
   ) resp_fifo (
      .clk_i     (clk_i),
      .reset_n_i (reset_n_i),
      .v_i       (ro_data_v_i),
      .data_i    (ro_data_i),
      .full_o    (fifo_full),
      .data_o    (data_o),
      .v_o       (fifo_v),
      .yumi_i    (yumi_i),
      .count_o   (fifo_count)
   );

   assign ro_addr_v_o = ro_v_q;
   assign ro_addr_o   = ro_addr_q;
   assign ro_dest_x_o = ro_x_q;
   assign v_o         = fifo_v;
   assign busy_o      = (state_q != IDLE);
   assign overflow_o  = overflow_q;

endmodule

// File: tb/tb_bsg_global_buffer_ro_streamer.sv
// Self-checking bench for the RO streamer: fixed-latency ring model, queue-based
// reference for request order, credit gating, FIFO contents and status flags.
module tb_bsg_global_buffer_ro_streamer;
   import bsg_global_buffer_pkg::*;

   localparam int DW = 32, NX = 4, F = 8, LW = 16, XW = 2, AW = 10, LAT = 6;

   logic          clk_i = 1'b0;
   logic          reset_n_i = 1'b0;
   logic          cmd_v_i = 1'b0;
   logic          cmd_ready_o;
   logic [XW-1:0] cmd_x_i = '0;
   logic [AW-1:0] cmd_addr_i = '0;
   logic [LW-1:0] cmd_len_i = '0;
   logic [AW-1:0] ro_addr_o;
   logic [XW-1:0] ro_dest_x_o;
   logic          ro_addr_v_o;
   logic [DW-1:0] ro_data_i = '0;
   logic          ro_data_v_i = 1'b0;
   logic [DW-1:0] data_o;
   logic          v_o;
   logic          yumi_i = 1'b0;
   logic          busy_o;
   logic          overflow_o;

   always #5 clk_i = ~clk_i;

   bsg_global_buffer_ro_streamer #(
      .data_width_p(DW), .bank_els_p(1024), .num_tiles_x_p(NX),
      .fifo_els_p(F), .len_width_p(LW)
   ) dut (
      .clk_i(clk_i), .reset_n_i(reset_n_i),
      .cmd_v_i(cmd_v_i), .cmd_ready_o(cmd_ready_o), .cmd_x_i(cmd_x_i),
      .cmd_addr_i(cmd_addr_i), .cmd_len_i(cmd_len_i),
      .ro_addr_o(ro_addr_o), .ro_dest_x_o(ro_dest_x_o), .ro_addr_v_o(ro_addr_v_o),
      .ro_data_i(ro_data_i), .ro_data_v_i(ro_data_v_i),
      .data_o(data_o), .v_o(v_o), .yumi_i(yumi_i),
      .busy_o(busy_o), .overflow_o(overflow_o)
   );

   typedef struct { int due; logic [31:0] d; } resp_t;

   resp_t       resp_q[$];
   int          req_x_q[$], req_a_q[$];
   logic [31:0] mfifo[$];
   int          log_x[$], log_a[$], log_c[$];

   int  checks = 0, failures = 0, cyc = 0;
   int  issued = 0, deqd = 0, received = 0, last_acc_cyc = 0;
   bit  active = 0, exp_rov = 0, exp_busy = 0, exp_ready = 0, exp_ovf = 0;
   int  exp_x = 0, exp_a = 0;
   bit  want_cmd = 0, spurious = 0, force_en = 0;
   ro_cmd_s     want_c;
   int          yumi_mode = 0;
   logic [31:0] spur_d = '0, force_d = '0;

   task automatic chk(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic logic [31:0] ring_word(input int x, input int a);
      return {8'hB5, 8'(x), 6'h0, 10'(a)};
   endfunction

   task automatic model_clear();
      resp_q.delete(); req_x_q.delete(); req_a_q.delete(); mfifo.delete();
      issued = 0; deqd = 0; received = 0; active = 0;
      exp_rov = 0; exp_busy = 0; exp_ovf = 0; exp_ready = 1;
      spurious = 0; want_cmd = 0;
   endtask

   task automatic log_clear();
      log_x.delete(); log_a.delete(); log_c.delete();
   endtask

   // One clock: check this cycle's outputs, drive this cycle's inputs,
   // then advance the reference to predict the next cycle.
   task automatic step();
      bit acc, yumi, dv, do_issue;
      logic [31:0] dd;
      int outst;
      @(negedge clk_i);
      cyc++;
      chk("ro_v", ro_addr_v_o, exp_rov);
      if (exp_rov) begin
         chk("ro_dest_x", ro_dest_x_o, exp_x);
         chk("ro_addr", ro_addr_o, exp_a);
      end
      chk("v_o", v_o, mfifo.size() > 0);
      if (mfifo.size() > 0) chk("data_o", data_o, mfifo[0]);
      chk("busy", busy_o, exp_busy);
      chk("cmd_ready", cmd_ready_o, exp_ready);
      chk("overflow", overflow_o, exp_ovf);

      if (ro_addr_v_o) begin
         log_x.push_back(int'(ro_dest_x_o));
         log_a.push_back(int'(ro_addr_o));
         log_c.push_back(cyc);
      end

      dv = 0; dd = '0;
      if (resp_q.size() > 0 && resp_q[0].due == cyc) begin
         dv = 1; dd = resp_q[0].d; void'(resp_q.pop_front());
      end
      if (spurious) begin dv = 1; dd = spur_d; spurious = 0; end
      if (ro_addr_v_o)
         resp_q.push_back('{cyc + LAT, force_en ? force_d :
                            ring_word(int'(ro_dest_x_o), int'(ro_addr_o))});

      yumi = (mfifo.size() > 0) &&
             ((yumi_mode == 1) ||
              (yumi_mode == 2 && $urandom_range(0, 2) != 0) ||
              (yumi_mode == 3 && $urandom_range(0, 3) == 0));
      acc = want_cmd && exp_ready;

      cmd_v_i = want_cmd; cmd_x_i = want_c.x; cmd_addr_i = want_c.addr;
      cmd_len_i = want_c.len; yumi_i = yumi;
      ro_data_v_i = dv; ro_data_i = dd;

      if (acc) begin
         want_cmd = 0; active = 1; last_acc_cyc = cyc;
         for (int i = 0; i <= int'(want_c.len); i++) begin
            req_x_q.push_back((int'(want_c.x) + i) % NX);
            req_a_q.push_back((int'(want_c.addr) + (int'(want_c.x) + i) / NX) % (1 << AW));
         end
      end

      do_issue = active && (req_x_q.size() > 0) && ((issued - deqd) < F);
      exp_rov = do_issue;
      outst = issued - received;
      if (do_issue) begin
         exp_x = req_x_q.pop_front(); exp_a = req_a_q.pop_front(); issued++;
      end
      if (dv && (outst == 0 || (mfifo.size() == F && !yumi))) exp_ovf = 1;
      if (yumi) begin void'(mfifo.pop_front()); deqd++; end
      if (dv) begin
         if (outst > 0) received++;
         if (mfifo.size() < F) mfifo.push_back(dd);
      end
      if (active && req_x_q.size() == 0 && issued == received && mfifo.size() == 0)
         active = 0;
      exp_busy = active;
      exp_ready = !active;
   endtask

   task automatic run_idle(input string name, input int budget);
      int n = 0;
      while ((active || want_cmd) && n < budget) begin step(); n++; end
      chk({name, "_timeout"}, active || want_cmd, 0);
      repeat (2) step();
   endtask

   task automatic rst_check(input string name);
      chk({name, "_rst_ro_v"}, ro_addr_v_o, 0);
      chk({name, "_rst_ready"}, cmd_ready_o, 0);
      chk({name, "_rst_v"}, v_o, 0);
      chk({name, "_rst_busy"}, busy_o, 0);
      chk({name, "_rst_ovf"}, overflow_o, 0);
      chk({name, "_rst_addr"}, ro_addr_o, 0);
      chk({name, "_rst_dest"}, ro_dest_x_o, 0);
   endtask

   task automatic async_reset(input string name);
      @(posedge clk_i);
      #2 reset_n_i = 1'b0;
      #1 rst_check(name);
      cmd_v_i = 0; yumi_i = 0; ro_data_v_i = 0;
      repeat (2) @(negedge clk_i);
      model_clear();
      reset_n_i = 1'b1;
   endtask

   initial begin : main
      int wx[6];
      int wa[6];
      int d0, n;
      wx = '{3, 0, 1, 2, 3, 0};
      wa = '{10, 11, 11, 11, 11, 12};
      want_c = '0;

      #1 rst_check("init");
      repeat (2) @(negedge clk_i);
      model_clear();
      reset_n_i = 1'b1;

      // single word, forced response value
      log_clear(); force_en = 1; force_d = 32'hA5; yumi_mode = 0;
      want_c = '{x: 2'd2, addr: 10'd5, len: 16'd0}; want_cmd = 1;
      repeat (LAT + 4) step();
      chk("single_nreq", log_x.size(), 1);
      if (log_x.size() >= 1) begin
         chk("single_x", log_x[0], 2);
         chk("single_addr", log_a[0], 5);
         chk("single_lat", log_c[0] - last_acc_cyc, 1);
      end
      chk("single_v", v_o, 1);
      chk("single_data", data_o, 32'hA5);
      yumi_mode = 1;
      run_idle("single", 20);
      chk("single_busy", busy_o, 0);
      chk("single_ready", cmd_ready_o, 1);
      force_en = 0;

      // tile wrap sequence
      log_clear();
      want_c = '{x: 2'd3, addr: 10'd10, len: 16'd5}; want_cmd = 1;
      run_idle("wrap", 100);
      chk("wrap_n", log_x.size(), 6);
      if (log_x.size() >= 6) begin
         for (int i = 0; i < 6; i++) begin
            chk($sformatf("wrap_x%0d", i), log_x[i], wx[i]);
            chk($sformatf("wrap_a%0d", i), log_a[i], wa[i]);
            if (i > 0) chk($sformatf("wrap_c%0d", i), log_c[i] - log_c[0], i);
         end
      end

      // credit stall with consumer held off
      log_clear(); yumi_mode = 0; d0 = deqd;
      want_c = '{x: 2'd0, addr: 10'd100, len: 16'd19}; want_cmd = 1;
      repeat (40) step();
      chk("stall_nreq", log_x.size(), 8);
      chk("stall_ro_v", ro_addr_v_o, 0);
      yumi_mode = 1;
      run_idle("stall", 300);
      chk("stall_total", log_x.size(), 20);
      chk("stall_words", deqd - d0, 20);

      // slow consumer: FIFO hovers near full with concurrent enq/deq/issue
      yumi_mode = 3;
      want_c = '{x: 2'd1, addr: 10'd500, len: 16'd40}; want_cmd = 1;
      run_idle("nearfull", 800);
      chk("nearfull_ovf", overflow_o, 0);

      // randomized bursts
      for (int k = 0; k < 15; k++) begin
         want_c.x = 2'($urandom_range(0, 3));
         want_c.addr = 10'($urandom_range(0, 1023));
         want_c.len = 16'($urandom_range(0, 24));
         yumi_mode = $urandom_range(1, 3);
         want_cmd = 1;
         run_idle("rand", 800);
         repeat ($urandom_range(0, 3)) step();
      end
      chk("rand_ovf", overflow_o, 0);

      // spurious response while idle
      yumi_mode = 0; spur_d = 32'h5A; spurious = 1;
      repeat (3) step();
      chk("spur_ovf", overflow_o, 1);
      repeat (5) step();
      chk("spur_ovf_sticky", overflow_o, 1);
      async_reset("spur");
      repeat (2) step();
      chk("spur_ovf_clr", overflow_o, 0);

      // reset mid-burst with four requests in flight
      log_clear(); yumi_mode = 0;
      want_c = '{x: 2'd1, addr: 10'd200, len: 16'd15}; want_cmd = 1;
      n = 0;
      while (log_x.size() < 4 && n < 20) begin step(); n++; end
      chk("mid_reach4", log_x.size(), 4);
      async_reset("mid");
      log_clear();
      want_c = '{x: 2'd2, addr: 10'd300, len: 16'd9}; want_cmd = 1;
      repeat (30) step();
      chk("post_nreq", log_x.size(), 8);
      yumi_mode = 1;
      run_idle("post", 200);
      chk("post_total", log_x.size(), 10);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
